if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage placed directly after the pre-IF PC generator and before ID. Accepts `nextpc` from pre-IF through a request/address handshake on the instruction SRAM-like bus, and waits for the in-order read response. Holds the fetched instruction in a one-entry buffer while ID stalls, then delivers `{pc, inst}` to ID. Discards stale responses after a redirect.

## Interface
- Parameters: none.
- `clk` in 1: single clock for the stage.
- `reset` in 1: asynchronous, active-high reset.
- `pre_valid` in 1: pre-IF has a valid `nextpc`.
- `nextpc` in 32: fetch address from pre-IF.
- `if_allowin` out 1: `nextpc` consumed this cycle. Drives pre-IF `from_allowin`.
- `br_taken` in 1: redirect/flush from downstream.
  - The producer holds it (with its target) until it sees `if_allowin`=1 in the same cycle.
- `id_allowin` in 1: ID can accept this cycle.
- `if_to_id_valid` out 1: bus to ID is valid.
- `if_to_id_bus` out 64 (65 with `IF_ADEF_EN`): `{[64] adef, [63:32] pc, [31:0] inst}`.
- `inst_sram_req` out 1: request strobe.
- `inst_sram_wr` out 1: tied 0.
- `inst_sram_size` out 2: tied 2'b10.
- `inst_sram_wstrb` out 4: tied 0.
- `inst_sram_wdata` out 32: tied 0.
- `inst_sram_addr` out 32: equals `nextpc`.
- `inst_sram_addr_ok` in 1: request accepted.
- `inst_sram_data_ok` in 1: read data valid. Responses return in request order.
- `inst_sram_rdata` in 32: read data.

## Operation
- State: `if_valid`, `if_pc[31:0]`, `buf_valid`, `inst_buf[31:0]`, `discard`.
  - Reset (async): all cleared to 0.
  - Outputs during reset: `inst_sram_req`=0, `if_allowin`=0, `if_to_id_valid`=0.
- `slot_free = !if_valid || (if_ready_go && id_allowin)`.
- `inst_sram_req = pre_valid && slot_free && !discard`.
- `if_allowin = inst_sram_req && inst_sram_addr_ok`.
- `if_ready_go = if_valid && (buf_valid || (inst_sram_data_ok && !discard))`.
- `if_to_id_valid = if_ready_go && !br_taken`.
- `inst = buf_valid ? inst_buf : inst_sram_rdata`.
- Accept: on `if_allowin`, `if_valid`<=1 and `if_pc`<=`nextpc`. Otherwise, when `slot_free`, `if_valid`<=0.
- Buffer fill: on `data_ok && !discard && if_valid && !buf_valid` with the instruction not leaving (`!id_allowin || br_taken`), `inst_buf`<=`rdata` and `buf_valid`<=1.
- Buffer clear: when the instruction leaves, or on flush.
- Flush (`br_taken`=1):
  - Current instruction is dropped; `buf_valid`<=0.
  - `if_valid`<=`if_allowin`, so a request for the target issued in the same cycle is kept.
  - If the old response is still outstanding (`if_valid && !buf_valid && !data_ok`), `discard`<=1.
- `discard`: the next `data_ok` is swallowed and clears it. No new request is issued while it is set.
  - At most 1 live plus 1 discarded request are ever outstanding.
- Held `br_taken` over several cycles is idempotent: after the first cycle `if_valid`=0, so no second discard is set.

## Timing
- Minimum latency is 1 cycle: request accepted in cycle N, `data_ok` in N+1, `if_to_id_valid`=1 in N+1 (combinational pass of `rdata`).
- Back-to-back throughput is 1 instruction/cycle when `addr_ok` and `data_ok` are both immediate and `id_allowin`=1.
- `data_ok` with `id_allowin`=0: buffered. `if_to_id_valid` stays 1 from the buffer until ID accepts.
- `data_ok` in the same cycle as `br_taken`: the data is dropped and `discard` is not set.
- `reset` asserted mid-transaction: state clears immediately.
  - The outstanding bus response is not tracked; the SRAM side is reset by the same `reset`.

## Configuration
- `IF_ADEF_EN` defined:
  - When `pre_valid && slot_free && !discard && nextpc[1:0]!=0`, no SRAM request is issued.
  - `if_allowin`=1 internally, and the instruction is recorded with adef=1, `inst`=0.
  - `if_ready_go`=1 with no wait. Bus is 65 bits.
- `IF_ADEF_EN` undefined: no alignment check. Bus is 64 bits; every address goes to SRAM.

## Test plan
- Reset release with pre-IF at 0x1c000000, `addr_ok`/`data_ok` immediate, `id_allowin`=1 -> ID receives pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles.
- `id_allowin`=0 for 3 cycles after `data_ok`=0x02800421 -> `if_to_id_valid` stays 1, inst held at 0x02800421, no new `inst_sram_req`; delivered once when `id_allowin`=1.
- `addr_ok` delayed 2 cycles -> `if_allowin`=0 in those cycles, pre-IF PC unchanged, single request at the held address.
- `br_taken` with target 0x1c000100 while the response for 0x1c000008 is pending and `addr_ok`=0 -> `discard`=1; next `data_ok` is dropped; then 0x1c000100 is fetched and delivered; 0x1c000008 never reaches ID.
- With `IF_ADEF_EN`, `nextpc`=0x1c000102 -> no `inst_sram_req`; ID receives adef=1, pc=0x1c000102, inst=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues nextpc on the instruction SRAM bus, buffers one response, drops stale data after a redirect.
// Optional IF_ADEF_EN: misaligned fetch addresses skip the bus and reach ID flagged adef with inst=0.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        pre_valid,
  input  logic [31:0] nextpc,
  output logic        if_allowin,
  input  logic        br_taken,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
`ifdef IF_ADEF_EN
  output logic [64:0] if_to_id_bus,
`else
  output logic [63:0] if_to_id_bus,
`endif
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        discard_q, discard_d;

  logic        adef_hit;
  logic        adef_cur;
  logic        slot_free;
  logic        if_ready_go;
  logic        leaving;
  logic        fetch_ok;
  logic [31:0] inst;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = nextpc;

  // An adef instruction never has a bus response, so it is ready at once.
  assign if_ready_go = if_valid_q &&
                       (buf_valid_q || adef_cur || (inst_sram_data_ok && !discard_q));
  assign slot_free   = !if_valid_q || (if_ready_go && id_allowin);
  assign fetch_ok    = !reset && pre_valid && slot_free && !discard_q;

`ifdef IF_ADEF_EN
  logic adef_q, adef_d;

  assign adef_hit = fetch_ok && (nextpc[1:0] != 2'b00);
  assign adef_cur = adef_q;

  always_comb begin
    adef_d = adef_q;
    if (if_allowin) adef_d = adef_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) adef_q <= 1'b0;
    else       adef_q <= adef_d;
  end
`else
  assign adef_hit = 1'b0;
  assign adef_cur = 1'b0;
`endif

  assign inst_sram_req  = fetch_ok && !adef_hit;
  assign if_allowin     = (inst_sram_req && inst_sram_addr_ok) || adef_hit;
  assign if_to_id_valid = if_ready_go && !br_taken;
  assign leaving        = if_ready_go && id_allowin;

  assign inst = adef_cur    ? 32'h0      :
                buf_valid_q ? inst_buf_q : inst_sram_rdata;

`ifdef IF_ADEF_EN
  assign if_to_id_bus = {adef_cur, if_pc_q, inst};
`else
  assign if_to_id_bus = {if_pc_q, inst};
`endif

  always_comb begin
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    discard_d   = discard_q;
    if (discard_q && inst_sram_data_ok) discard_d = 1'b0;
    if (br_taken) begin
      // Keep a target request accepted in the flush cycle; mark the old response stale if still in flight.
      if_valid_d  = if_allowin;
      buf_valid_d = 1'b0;
      if (if_allowin) if_pc_d = nextpc;
      if (if_valid_q && !buf_valid_q && !adef_cur && !inst_sram_data_ok) discard_d = 1'b1;
    end else begin
      if (if_allowin) begin
        if_valid_d = 1'b1;
        if_pc_d    = nextpc;
      end else if (slot_free) begin
        if_valid_d = 1'b0;
      end
      if (leaving) begin
        buf_valid_d = 1'b0;
      end else if (inst_sram_data_ok && !discard_q && if_valid_q && !buf_valid_q && !adef_cur) begin
        buf_valid_d = 1'b1;
        inst_buf_d  = inst_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
      discard_q   <= 1'b0;
    end else begin
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
      discard_q   <= discard_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each cycle drives inputs after the clock edge and checks outputs before the next edge.
module tb_if_stage;

`ifdef IF_ADEF_EN
  localparam int BW = 65;
`else
  localparam int BW = 64;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pre_valid;
  logic [31:0]   nextpc;
  logic          if_allowin;
  logic          br_taken;
  logic          id_allowin;
  logic          if_to_id_valid;
  logic [BW-1:0] if_to_id_bus;
  logic          inst_sram_req;
  logic          inst_sram_wr;
  logic [1:0]    inst_sram_size;
  logic [3:0]    inst_sram_wstrb;
  logic [31:0]   inst_sram_wdata;
  logic [31:0]   inst_sram_addr;
  logic          inst_sram_addr_ok;
  logic          inst_sram_data_ok;
  logic [31:0]   inst_sram_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .pre_valid         (pre_valid),
    .nextpc            (nextpc),
    .if_allowin        (if_allowin),
    .br_taken          (br_taken),
    .id_allowin        (id_allowin),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_bus      (if_to_id_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Apply one cycle of inputs just after a rising edge, then let combinational outputs settle.
  task automatic drv(input logic pv, input logic [31:0] pc, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic ida, input logic br);
    pre_valid         = pv;
    nextpc            = pc;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
    id_allowin        = ida;
    br_taken          = br;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Checks valid/req/allowin and, when valid is expected, the delivered {pc, inst}.
  task automatic exp_out(input string tag, input logic v, input logic rq, input logic al,
                         input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"},   {64'h0, if_to_id_valid}, {64'h0, v});
    chk({tag, ".req"},     {64'h0, inst_sram_req},  {64'h0, rq});
    chk({tag, ".allowin"}, {64'h0, if_allowin},     {64'h0, al});
    if (v) chk({tag, ".bus"}, {1'b0, if_to_id_bus[63:0]}, {1'b0, pc, ins});
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b1, 32'h1c000000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    nxt();
    nxt();
    exp_out("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reset.wr",    {64'h0, inst_sram_wr},    65'h0);
    chk("reset.size",  {63'h0, inst_sram_size},  65'h2);
    chk("reset.wstrb", {61'h0, inst_sram_wstrb}, 65'h0);
    chk("reset.wdata", {33'h0, inst_sram_wdata}, 65'h0);
    chk("reset.addr",  {33'h0, inst_sram_addr},  {33'h0, 32'h1c000000});

    // Back-to-back fetch at 1 instruction/cycle.
    reset = 1'b0;
    drv(1'b1, 32'h1c000000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    exp_out("b2b.c0", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b1, 32'h1c000004, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0);
    exp_out("b2b.c1", 1'b1, 1'b1, 1'b1, 32'h1c000000, 32'h11111111);
    nxt();
    drv(1'b1, 32'h1c000008, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b0);
    exp_out("b2b.c2", 1'b1, 1'b1, 1'b1, 32'h1c000004, 32'h22222222);
    nxt();
    drv(1'b0, 32'h1c00000c, 1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0);
    exp_out("b2b.c3", 1'b1, 1'b0, 1'b0, 32'h1c000008, 32'h33333333);
    nxt();

    // ID stall: response buffered and held until ID accepts.
    drv(1'b1, 32'h1c00000c, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    exp_out("stall.req", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b1, 32'h1c000010, 1'b1, 1'b1, 32'h02800421, 1'b0, 1'b0);
    exp_out("stall.dok", 1'b1, 1'b0, 1'b0, 32'h1c00000c, 32'h02800421);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 32'h1c000010, 1'b1, 1'b0, 32'hdeadbeef, 1'b0, 1'b0);
      exp_out($sformatf("stall.hold%0d", i), 1'b1, 1'b0, 1'b0, 32'h1c00000c, 32'h02800421);
      nxt();
    end
    drv(1'b1, 32'h1c000010, 1'b1, 1'b0, 32'hdeadbeef, 1'b1, 1'b0);
    exp_out("stall.go", 1'b1, 1'b1, 1'b1, 32'h1c00000c, 32'h02800421);
    nxt();
    drv(1'b0, 32'h1c000014, 1'b0, 1'b0, 32'hdeadbeef, 1'b1, 1'b0);
    exp_out("stall.once", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    drv(1'b0, 32'h1c000014, 1'b0, 1'b1, 32'h44444444, 1'b1, 1'b0);
    exp_out("stall.next", 1'b1, 1'b0, 1'b0, 32'h1c000010, 32'h44444444);
    nxt();

    // addr_ok delayed two cycles: request held at the same address.
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 32'h1c000014, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      exp_out($sformatf("aok.wait%0d", i), 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      chk($sformatf("aok.addr%0d", i), {33'h0, inst_sram_addr}, {33'h0, 32'h1c000014});
      nxt();
    end
    drv(1'b1, 32'h1c000014, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    exp_out("aok.acc", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b0, 32'h1c000018, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b0);
    exp_out("aok.dok", 1'b1, 1'b0, 1'b0, 32'h1c000014, 32'h55555555);
    nxt();

    // Redirect while 0x1c000008 is pending: its response is discarded.
    drv(1'b1, 32'h1c000008, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    exp_out("br.acc", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b1, 32'h1c000100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    exp_out("br.flush", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    drv(1'b1, 32'h1c000100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    exp_out("br.blocked", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    drv(1'b1, 32'h1c000100, 1'b1, 1'b1, 32'h0bad0008, 1'b1, 1'b1);
    exp_out("br.swallow", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    drv(1'b1, 32'h1c000100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    exp_out("br.target", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b0, 32'h1c000104, 1'b0, 1'b1, 32'h66666666, 1'b1, 1'b0);
    exp_out("br.deliver", 1'b1, 1'b0, 1'b0, 32'h1c000100, 32'h66666666);
    nxt();

    // data_ok together with br_taken: data dropped, no discard left behind.
    drv(1'b1, 32'h1c000200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    nxt();
    drv(1'b1, 32'h1c000300, 1'b1, 1'b1, 32'h0bad0200, 1'b1, 1'b1);
    exp_out("brdok.flush", 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b0, 32'h1c000304, 1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0);
    exp_out("brdok.next", 1'b1, 1'b0, 1'b0, 32'h1c000300, 32'h77777777);
    nxt();

    // Reset mid-transaction clears state immediately.
    drv(1'b1, 32'h1c000400, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    nxt();
    drv(1'b1, 32'h1c000404, 1'b1, 1'b1, 32'h88888888, 1'b1, 1'b0);
    chk("rst.pre", {64'h0, if_to_id_valid}, 65'h1);
    reset = 1'b1;
    #1;
    exp_out("rst.mid", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt();
    reset = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    exp_out("rst.after", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nxt();

`ifdef IF_ADEF_EN
    // Misaligned address: no bus request, adef delivered with inst=0.
    drv(1'b1, 32'h1c000102, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    exp_out("adef.acc", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    nxt();
    drv(1'b0, 32'h1c000104, 1'b0, 1'b0, 32'h99999999, 1'b1, 1'b0);
    exp_out("adef.out", 1'b1, 1'b0, 1'b0, 32'h1c000102, 32'h0);
    chk("adef.flag", {64'h0, if_to_id_bus[BW-1]}, 65'h1);
    nxt();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
